// File: rtl/axi_bridge_ip_tx_pkg.sv
// rtl/axi_bridge_ip_tx_pkg.sv - shared types and tkeep helpers for the AXI bridge TX path
package axi_bridge_ip_tx_pkg;

   localparam int MAX_KEEP_W = 64;
   localparam int KEEP_CNT_W = $clog2(MAX_KEEP_W) + 1;

   typedef enum logic [1:0] {IDLE, BODY, TRUNC} pkt_chk_state_e;

   typedef struct packed {
      logic null_err;
      logic ovf_err;
      logic keep_err;
   } pkt_err_t;

   function automatic logic [KEEP_CNT_W-1:0] popcount_keep_fixed(input logic [MAX_KEEP_W-1:0] keep);
      logic [KEEP_CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < MAX_KEEP_W; i++) begin
         cnt = cnt + KEEP_CNT_W'(keep[i]);
      end
      return cnt;
   endfunction

   // keep is zero-extended from nbytes, so bits above the lane count never set
   function automatic logic tkeep_illegal_f_fixed(input logic [MAX_KEEP_W-1:0] keep,
                                                  input int nbytes, input logic last);
      logic [MAX_KEEP_W-1:0] full_mask;
      full_mask = '0;
      for (int i = 0; i < MAX_KEEP_W; i++) begin
         if (i < nbytes) full_mask[i] = 1'b1;
      end
      if (!last) return keep != full_mask;
      return (keep & (keep + MAX_KEEP_W'(1))) != '0;
   endfunction

endpackage

// File: rtl/axi_bridge_tx_skid.sv
// rtl/axi_bridge_tx_skid.sv - 2-entry registered slice, full throughput with registered outputs
module axi_bridge_tx_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         has_space,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] data
);

   logic [W-1:0] mem [2];
   logic         wr_ptr, rd_ptr;
   logic [1:0]   count;
   logic         push_ok, pop;

   assign has_space = (count != 2'd2);
   assign valid     = (count != 2'd0);
   assign data      = mem[rd_ptr];
   assign push_ok   = push && has_space;
   assign pop       = valid && ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop)     rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/axi_bridge_tx_pkt_checker.sv
// rtl/axi_bridge_tx_pkt_checker.sv - TX ingress tkeep/size checker with truncation and descriptor FIFO
// Optional statistics counters enabled by AXI_BRIDGE_TX_PKT_STATS_EN.
module axi_bridge_tx_pkt_checker
   import axi_bridge_ip_tx_pkg::*;
#(
   parameter int DATA_W          = 64,
   parameter int MAX_PKT_BYTES   = 256,
   parameter int LEN_W           = 16,
   parameter int DESC_DEPTH      = 4,
   parameter bit ALLOW_NULL_LAST = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_tvalid,
   output logic                s_tready,
   input  logic [DATA_W-1:0]   s_tdata,
   input  logic [DATA_W/8-1:0] s_tkeep,
   input  logic                s_tlast,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic [DATA_W-1:0]   m_tdata,
   output logic [DATA_W/8-1:0] m_tkeep,
   output logic                m_tlast,
   output logic                m_terr,
   output logic                desc_valid,
   input  logic                desc_ready,
   output logic [LEN_W-1:0]    desc_len,
   output logic [2:0]          desc_err
`ifdef AXI_BRIDGE_TX_PKT_STATS_EN
  ,output logic [31:0]         stat_pkts,
   output logic [31:0]         stat_errs
`endif
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int SKID_W = DATA_W + KEEP_W + 2;
   localparam int DAW    = $clog2(DESC_DEPTH);
   localparam logic [LEN_W:0] LEN_MAX = {1'b0, {LEN_W{1'b1}}};
   localparam logic [LEN_W:0] PKT_MAX = (LEN_W+1)'(MAX_PKT_BYTES);

   pkt_chk_state_e state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_sat, push_len;
   logic [LEN_W:0]        len_sum;
   pkt_err_t              err_q, beat_err, err_all, push_err;
   logic [MAX_KEEP_W-1:0] keep_ext;
   logic                  accept, beat_ovf, fwd, fwd_last, fwd_err, desc_push, desc_pop;
   logic                  skid_space, skid_last, skid_err, desc_full, desc_empty;

   assign keep_ext = MAX_KEEP_W'(s_tkeep);
   assign s_tready = !rst && skid_space && !desc_full;
   assign accept   = s_tvalid && s_tready;

   // len_q is zero whenever the FSM sits in IDLE, so the same sum serves the first beat
   assign len_sum  = {1'b0, len_q} + (LEN_W+1)'(popcount_keep_fixed(keep_ext));
   assign len_sat  = (len_sum > LEN_MAX) ? LEN_MAX[LEN_W-1:0] : len_sum[LEN_W-1:0];
   assign beat_ovf = (len_sum > PKT_MAX);

   assign beat_err.keep_err = tkeep_illegal_f_fixed(keep_ext, KEEP_W, s_tlast);
   assign beat_err.null_err = s_tlast && (s_tkeep == '0) && !ALLOW_NULL_LAST;
   assign beat_err.ovf_err  = beat_ovf;
   assign err_all           = pkt_err_t'(err_q | beat_err);

   always_comb begin
      state_d   = state_q;
      fwd       = 1'b0;
      fwd_last  = 1'b0;
      fwd_err   = 1'b0;
      desc_push = 1'b0;
      push_len  = len_q;
      push_err  = err_q;
      case (state_q)
         IDLE, BODY: begin
            if (accept) begin
               fwd       = 1'b1;
               fwd_last  = s_tlast || beat_ovf;
               fwd_err   = fwd_last && (err_all != '0);
               push_len  = len_sat;
               push_err  = err_all;
               desc_push = s_tlast;
               if (s_tlast)       state_d = IDLE;
               else if (beat_ovf) state_d = TRUNC;
               else               state_d = BODY;
            end
         end
         TRUNC: begin
            if (accept && s_tlast) begin
               desc_push = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         if (desc_push) begin
            len_q <= '0;
            err_q <= '0;
         end else if (fwd) begin
            len_q <= len_sat;
            err_q <= err_all;
         end
      end
   end

   axi_bridge_tx_skid #(.W(SKID_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (fwd),
      .push_data ({s_tdata, s_tkeep, fwd_last, fwd_err}),
      .has_space (skid_space),
      .valid     (m_tvalid),
      .ready     (m_tready),
      .data      ({m_tdata, m_tkeep, skid_last, skid_err})
   );

   assign m_tlast = m_tvalid && skid_last;
   assign m_terr  = m_tvalid && skid_err;

   // Descriptor FIFO: extra pointer bit tells full from empty
   logic [LEN_W+2:0] desc_mem [DESC_DEPTH];
   logic [DAW:0]     wr_q, rd_q;

   assign desc_empty = (wr_q == rd_q);
   assign desc_full  = (wr_q[DAW] != rd_q[DAW]) && (wr_q[DAW-1:0] == rd_q[DAW-1:0]);
   assign desc_valid = !desc_empty;
   assign desc_pop   = desc_valid && desc_ready;
   assign {desc_len, desc_err} = desc_valid ? desc_mem[rd_q[DAW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (desc_push) wr_q <= wr_q + (DAW+1)'(1);
         if (desc_pop)  rd_q <= rd_q + (DAW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (desc_push) desc_mem[wr_q[DAW-1:0]] <= {push_len, push_err};
   end

`ifdef AXI_BRIDGE_TX_PKT_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_pkts <= '0;
         stat_errs <= '0;
      end else if (desc_push) begin
         stat_pkts <= stat_pkts + 32'd1;
         if (push_err != '0) stat_errs <= stat_errs + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axi_bridge_tx_pkt_checker.sv
// tb/tb_axi_bridge_tx_pkt_checker.sv - self-checking bench for axi_bridge_tx_pkt_checker
module tb_axi_bridge_tx_pkt_checker;

   localparam int MAXB = 32;

   logic        clk = 1'b0;
   logic        rst, s_tvalid, s_tlast, m_tready, desc_ready;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic        s_tready, m_tvalid, m_tlast, m_terr, desc_valid;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic [15:0] desc_len;
   logic [2:0]  desc_err;
   logic        s_tready_n, m_tvalid_n, m_tlast_n, m_terr_n, desc_valid_n;
   logic [63:0] m_tdata_n;
   logic [7:0]  m_tkeep_n;
   logic [15:0] desc_len_n;
   logic [2:0]  desc_err_n;
`ifdef AXI_BRIDGE_TX_PKT_STATS_EN
   logic [31:0] stat_pkts, stat_errs, stat_pkts_n, stat_errs_n;
`endif

   always #5 clk = ~clk;

   axi_bridge_tx_pkt_checker #(.DATA_W(64), .MAX_PKT_BYTES(MAXB), .LEN_W(16), .DESC_DEPTH(2),
                               .ALLOW_NULL_LAST(1'b0)) dut (
      .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_terr(m_terr),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len), .desc_err(desc_err)
`ifdef AXI_BRIDGE_TX_PKT_STATS_EN
     ,.stat_pkts(stat_pkts), .stat_errs(stat_errs)
`endif
   );

   axi_bridge_tx_pkt_checker #(.DATA_W(64), .MAX_PKT_BYTES(MAXB), .LEN_W(16), .DESC_DEPTH(2),
                               .ALLOW_NULL_LAST(1'b1)) dut_n (
      .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready_n), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .m_tvalid(m_tvalid_n), .m_tready(m_tready),
      .m_tdata(m_tdata_n), .m_tkeep(m_tkeep_n), .m_tlast(m_tlast_n), .m_terr(m_terr_n),
      .desc_valid(desc_valid_n), .desc_ready(desc_ready), .desc_len(desc_len_n), .desc_err(desc_err_n)
`ifdef AXI_BRIDGE_TX_PKT_STATS_EN
     ,.stat_pkts(stat_pkts_n), .stat_errs(stat_errs_n)
`endif
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        err;
   } beat_t;

   typedef struct packed {
      logic [15:0] len;
      logic [2:0]  err;
   } desc_t;

   typedef struct {
      int              n;
      logic [7:0][7:0] keeps;
      logic [15:0]     len;
      logic [2:0]      err;
      logic [2:0]      err_n;
      int              nout;
   } vec_t;

   beat_t       exp_beats[$];
   desc_t       exp_desc[$], exp_desc_n[$];
   beat_t       mon_b;
   desc_t       mon_d, last_desc, last_desc_n;
   int          total = 0, bad = 0, n_beats = 0, n_desc = 0;
   bit          rand_sinks = 1'b0, rand_gaps = 1'b0;
   logic [63:0] pkt_data [8];
   logic [7:0]  pkt_keep [8];
   int          pkt_n;
   vec_t        vecs [8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Packet-level reference: walk the beats, accumulate bytes, stop forwarding after overflow
   function automatic desc_t ref_pkt(input bit allow_null, input bit emit);
      int          bytes;
      int          pc;
      logic [2:0]  e;
      logic [8:0]  lowmask;
      bit          trunc, last;
      bytes = 0; e = 3'b000; trunc = 1'b0;
      for (int i = 0; i < pkt_n; i++) begin
         if (!trunc) begin
            pc      = $countones(pkt_keep[i]);
            last    = (i == pkt_n - 1);
            lowmask = (9'd1 << pc) - 9'd1;
            if (last ? (pkt_keep[i] != lowmask[7:0]) : (pkt_keep[i] != 8'hFF)) e[0] = 1'b1;
            if (last && pkt_keep[i] == 8'h00 && !allow_null) e[2] = 1'b1;
            bytes += pc;
            if (bytes > MAXB) begin
               e[1]  = 1'b1;
               trunc = 1'b1;
            end
            if (emit) exp_beats.push_back('{pkt_data[i], pkt_keep[i], last || trunc,
                                            (last || trunc) && (e != 3'b000)});
         end
      end
      return '{(bytes > 65535) ? 16'hFFFF : bytes[15:0], e};
   endfunction

   task automatic queue_pkt();
      exp_desc.push_back(ref_pkt(1'b0, 1'b1));
      exp_desc_n.push_back(ref_pkt(1'b1, 1'b0));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (m_tvalid && m_tready) begin
            n_beats++;
            check("beat_expected", exp_beats.size() != 0, 1);
            if (exp_beats.size() != 0) begin
               mon_b = exp_beats.pop_front();
               check("beat", {m_tdata, m_tkeep, m_tlast, m_terr}, mon_b);
            end
         end
         if (desc_valid && desc_ready) begin
            n_desc++;
            last_desc = '{desc_len, desc_err};
            check("desc_expected", exp_desc.size() != 0, 1);
            if (exp_desc.size() != 0) begin
               mon_d = exp_desc.pop_front();
               check("desc", last_desc, mon_d);
            end
         end
         if (desc_valid_n && desc_ready) begin
            last_desc_n = '{desc_len_n, desc_err_n};
            check("desc_n_expected", exp_desc_n.size() != 0, 1);
            if (exp_desc_n.size() != 0) begin
               mon_d = exp_desc_n.pop_front();
               check("desc_n", last_desc_n, mon_d);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_sinks) begin
         m_tready   = ($urandom_range(0, 3) != 0);
         desc_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      bit rdy;
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
      rdy = 1'b0;
      for (int t = 0; t < 300 && !rdy; t++) begin
         @(negedge clk);
         rdy = s_tready;
         tick();
      end
      s_tvalid = 1'b0;
      check("accepted", rdy, 1);
   endtask

   task automatic send_pkt();
      queue_pkt();
      for (int i = 0; i < pkt_n; i++) begin
         if (rand_gaps && $urandom_range(0, 3) == 0) tick();
         send_beat(pkt_data[i], pkt_keep[i], i == pkt_n - 1);
      end
   endtask

   task automatic drain();
      m_tready = 1'b1; desc_ready = 1'b1;
      for (int t = 0; t < 300 && (exp_beats.size() + exp_desc.size() + exp_desc_n.size()) != 0; t++)
         tick();
      tick();
      check("drain_beats", exp_beats.size(), 0);
      check("drain_desc", exp_desc.size(), 0);
      check("drain_desc_n", exp_desc_n.size(), 0);
   endtask

   task automatic one_beat(input logic [7:0] k);
      pkt_n = 1; pkt_keep[0] = k; pkt_data[0] = {$urandom, $urandom};
   endtask

   initial begin
      int nb0, nd0;
      vecs[0] = '{3, 64'h07FFFF,       16'd19, 3'b000, 3'b000, 3};
      vecs[1] = '{2, 64'hFF7F,         16'd15, 3'b001, 3'b001, 2};
      vecs[2] = '{2, 64'h0BFF,         16'd11, 3'b001, 3'b001, 2};
      vecs[3] = '{1, 64'h00,           16'd0,  3'b100, 3'b000, 1};
      vecs[4] = '{6, 64'hFFFFFFFFFFFF, 16'd40, 3'b010, 3'b010, 5};
      vecs[5] = '{4, 64'hFFFFFFFF,     16'd32, 3'b000, 3'b000, 4};
      vecs[6] = '{5, 64'h00FFFFFFFF,   16'd32, 3'b100, 3'b000, 5};
      vecs[7] = '{1, 64'h01,           16'd1,  3'b000, 3'b000, 1};

      rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
      m_tready = 1'b1; desc_ready = 1'b1;
      repeat (3) tick();
      check("rst_s_tready", s_tready, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_terr", m_terr, 0);
      check("rst_desc_valid", desc_valid, 0);
      check("rst_desc_len", desc_len, 0);
      check("rst_desc_err", desc_err, 0);
      rst = 1'b0;
      tick();

      one_beat(8'h3F);
      queue_pkt();
      send_beat(pkt_data[0], 8'h3F, 1'b1);
      check("lat_valid", m_tvalid, 1);
      check("lat_data", m_tdata, pkt_data[0]);
      check("lat_last", m_tlast, 1);
      drain();

      for (int v = 0; v < 8; v++) begin
         pkt_n = vecs[v].n;
         for (int i = 0; i < pkt_n; i++) begin
            pkt_keep[i] = vecs[v].keeps[i];
            pkt_data[i] = {$urandom, $urandom};
         end
         nb0 = n_beats;
         send_pkt();
         drain();
         check($sformatf("vec%0d_len", v), last_desc.len, vecs[v].len);
         check($sformatf("vec%0d_err", v), last_desc.err, vecs[v].err);
         check($sformatf("vec%0d_err_null_ok", v), last_desc_n.err, vecs[v].err_n);
         check($sformatf("vec%0d_nout", v), n_beats - nb0, vecs[v].nout);
      end

      // Backpressure: two packets fill both skid and descriptor FIFO
      m_tready = 1'b0; desc_ready = 1'b0;
      nb0 = n_beats; nd0 = n_desc;
      one_beat(8'h01); queue_pkt(); send_beat(pkt_data[0], 8'h01, 1'b1);
      nb0 = nb0; 
      begin
         logic [63:0] first_data;
         first_data = pkt_data[0];
         one_beat(8'h03); queue_pkt(); send_beat(pkt_data[0], 8'h03, 1'b1);
         one_beat(8'h07); queue_pkt();
         s_tdata = pkt_data[0]; s_tkeep = 8'h07; s_tlast = 1'b1; s_tvalid = 1'b1;
         repeat (20) tick();
         check("bp_s_tready_low", s_tready, 0);
         check("bp_m_tvalid_held", m_tvalid, 1);
         check("bp_m_tdata_stable", m_tdata, first_data);
         check("bp_desc_valid", desc_valid, 1);
         m_tready = 1'b1; desc_ready = 1'b1;
         send_beat(pkt_data[0], 8'h07, 1'b1);
      end
      drain();
      check("bp_desc_count", n_desc - nd0, 3);
      check("bp_beat_count", n_beats - nb0, 3);

      // Randomized traffic with random sink stalls and source gaps
      rand_sinks = 1'b1; rand_gaps = 1'b1;
      for (int p = 0; p < 40; p++) begin
         pkt_n = $urandom_range(1, 7);
         for (int i = 0; i < pkt_n; i++) begin
            pkt_data[i] = {$urandom, $urandom};
            if (i < pkt_n - 1) begin
               pkt_keep[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
            end else begin
               case ($urandom_range(0, 9))
                  0:       pkt_keep[i] = 8'h00;
                  1:       pkt_keep[i] = 8'($urandom);
                  default: pkt_keep[i] = 8'hFF >> $urandom_range(0, 7);
               endcase
            end
         end
         send_pkt();
      end
      rand_sinks = 1'b0; rand_gaps = 1'b0;
      drain();

      // Reset in the middle of a 4-beat packet
      pkt_n = 4;
      for (int i = 0; i < 4; i++) begin
         pkt_keep[i] = 8'hFF;
         pkt_data[i] = {$urandom, $urandom};
      end
      queue_pkt();
      send_beat(pkt_data[0], 8'hFF, 1'b0);
      send_beat(pkt_data[1], 8'hFF, 1'b0);
      rst = 1'b1;
      tick();
      check("mid_rst_s_tready", s_tready, 0);
      check("mid_rst_m_tvalid", m_tvalid, 0);
      check("mid_rst_m_tlast", m_tlast, 0);
      check("mid_rst_m_terr", m_terr, 0);
      check("mid_rst_desc_valid", desc_valid, 0);
      check("mid_rst_desc_len", desc_len, 0);
      check("mid_rst_desc_err", desc_err, 0);
      exp_beats.delete(); exp_desc.delete(); exp_desc_n.delete();
      rst = 1'b0;
      tick();
      one_beat(8'h0F);
      send_pkt();
      drain();
      check("post_rst_len", last_desc.len, 4);
      check("post_rst_err", last_desc.err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
